gpi_irq_periph: RTL and testbench

GPI_IRQ_PERIPH -- requirements
Module: gpi_irq_periph

---
 rtl/gpi_irq_pkg.sv | 27 ++
 rtl/gpi_sync_edge.sv | 32 +++
 rtl/gpi_irq_periph.sv | 120 ++++++++++++
 tb/tb_gpi_irq_periph.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/gpi_irq_pkg.sv
// Shared register map for the APB general-purpose input block.
// Offsets and the word-index enum used by the address decoder.
package gpi_irq_pkg;

  localparam logic [4:0] OFF_MODER   = 5'h00;
  localparam logic [4:0] OFF_IDR     = 5'h04;
  localparam logic [4:0] OFF_RIER    = 5'h08;
  localparam logic [4:0] OFF_FIER    = 5'h0C;
  localparam logic [4:0] OFF_ISR     = 5'h10;
  localparam logic [4:0] OFF_IER_GLB = 5'h14;

  typedef enum logic [2:0] {
    IDX_MODER   = 3'd0,
    IDX_IDR     = 3'd1,
    IDX_RIER    = 3'd2,
    IDX_FIER    = 3'd3,
    IDX_ISR     = 3'd4,
    IDX_IER_GLB = 3'd5,
    IDX_RSV6    = 3'd6,
    IDX_RSV7    = 3'd7
  } reg_idx_e;

  function automatic reg_idx_e addr_to_idx(input logic [4:0] a);
    return reg_idx_e'(a[4:2]);
  endfunction

endpackage

// File: rtl/gpi_sync_edge.sv
// Pin synchroniser with previous-sample register.
// Emits unmasked per-bit rising and falling edge strobes.
module gpi_sync_edge #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync_q,
  output logic [WIDTH-1:0] rise_raw,
  output logic [WIDTH-1:0] fall_raw
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_r;
  logic [WIDTH-1:0]                  prev;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      sync_r <= '0;
      prev   <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], in_port};
      prev   <= sync_r[SYNC_STAGES-1];
    end
  end

  assign sync_q   = sync_r[SYNC_STAGES-1];
  assign rise_raw = sync_q & ~prev;
  assign fall_raw = ~sync_q & prev;

endmodule

// File: rtl/gpi_irq_periph.sv
// APB general-purpose input port with edge interrupts.
// One wait state per transfer; irq is a pure register function.
module gpi_irq_periph
  import gpi_irq_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic [4:0]       PADDR,
  input  logic [31:0]      PWDATA,
  input  logic             PWRITE,
  input  logic             PSEL,
  input  logic             PENABLE,
  output logic [31:0]      PRDATA,
  output logic             PREADY,
  output logic             PSLVERR,
  input  logic [WIDTH-1:0] inPort,
  output logic             irq
);

  logic [WIDTH-1:0] moder;
  logic [WIDTH-1:0] rier;
  logic [WIDTH-1:0] fier;
  logic [WIDTH-1:0] isr;
  logic             ier_glb;

  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] rise_raw;
  logic [WIDTH-1:0] fall_raw;
  logic [WIDTH-1:0] idr;
  logic [WIDTH-1:0] isr_set;
  logic [WIDTH-1:0] isr_clr;
  logic [WIDTH-1:0] wdat;
  logic [31:0]      rdata;
  reg_idx_e         idx;
  logic             access;
  logic             wr;
  logic             rd;
  logic             unmapped;
  logic             unused_bits;

  gpi_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .in_port  (inPort),
    .sync_q   (sync_q),
    .rise_raw (rise_raw),
    .fall_raw (fall_raw)
  );

  assign idx      = addr_to_idx(PADDR);
  assign access   = PSEL & PENABLE & ~PREADY;
  assign wr       = access & PWRITE;
  assign rd       = access & ~PWRITE;
  assign unmapped = (idx == IDX_RSV6) || (idx == IDX_RSV7);
  assign wdat     = PWDATA[WIDTH-1:0];
  assign idr      = sync_q & ~moder;

  assign unused_bits = ^{PADDR[1:0], PWDATA};

  // A fresh edge in the same cycle as a W1C clear keeps the bit set.
  assign isr_set = ((rise_raw & rier) | (fall_raw & fier)) & ~moder;
  assign isr_clr = (wr && idx == IDX_ISR) ? wdat : '0;

  always_comb begin
    rdata = '0;
    unique case (idx)
      IDX_MODER:   rdata = 32'(moder);
      IDX_IDR:     rdata = 32'(idr);
      IDX_RIER:    rdata = 32'(rier);
      IDX_FIER:    rdata = 32'(fier);
      IDX_ISR:     rdata = 32'(isr);
      IDX_IER_GLB: rdata = {31'd0, ier_glb};
      IDX_RSV6,
      IDX_RSV7:    rdata = '0;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
    end else begin
      PREADY  <= access;
      PSLVERR <= access & unmapped;
      if (rd) PRDATA <= rdata;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      moder   <= '0;
      rier    <= '0;
      fier    <= '0;
      ier_glb <= 1'b0;
    end else if (wr) begin
      unique case (1'b1)
        idx == IDX_MODER:   moder   <= wdat;
        idx == IDX_RIER:    rier    <= wdat;
        idx == IDX_FIER:    fier    <= wdat;
        idx == IDX_IER_GLB: ier_glb <= PWDATA[0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) isr <= '0;
    else        isr <= (isr & ~isr_clr) | isr_set;
  end

  assign irq = ier_glb & (|isr);

endmodule

// File: tb/tb_gpi_irq_periph.sv
// Scoreboard bench for gpi_irq_periph (WIDTH=8, SYNC_STAGES=2).
// Stimulus queues expected APB responses; a monitor checks them.
module tb_gpi_irq_periph;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [4:0]  PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [7:0]  inPort;
  logic        irq;

  typedef struct {
    logic        rd;
    logic [31:0] data;
    logic        err;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rd = '0;
  logic        prev_rdy = 1'b0;

  gpi_irq_periph #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PWRITE  (PWRITE),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .inPort  (inPort),
    .irq     (irq)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge PCLK) begin
    if (PRESET) begin
      prev_rdy = 1'b0;
    end else begin
      if (PREADY) begin
        chk("pready_one_cycle", 32'(prev_rdy), 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_pready", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk({e.name, "_prdata"}, PRDATA, e.data);
          chk({e.name, "_pslverr"}, 32'(PSLVERR), 32'(e.err));
        end
      end else if (PSLVERR) begin
        chk("pslverr_idle", 32'(PSLVERR), 32'd0);
      end
      prev_rdy = PREADY;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic apb(input logic w, input logic [4:0] a,
                     input logic [31:0] d, input logic [31:0] ed,
                     input logic ee, input string nm);
    exp_t e;
    int   n;
    e.rd   = ~w;
    e.err  = ee;
    e.name = nm;
    if (w) e.data = last_rd;
    else begin
      e.data  = ed;
      last_rd = ed;
    end
    exp_q.push_back(e);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0;
    PADDR = a; PWDATA = d; PWRITE = w;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    n = 0;
    @(posedge PCLK); #1;
    while (!PREADY && n < 8) begin
      @(posedge PCLK); #1;
      n++;
    end
    if (!PREADY) chk({nm, "_timeout"}, 32'd1, 32'd0);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d,
                    input string nm);
    apb(1'b1, a, d, '0, 1'b0, nm);
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] ed,
                    input string nm);
    apb(1'b0, a, '0, ed, 1'b0, nm);
  endtask

  initial begin
    PRESET = 1'b1; PADDR = '0; PWDATA = '0; PWRITE = 1'b0;
    PSEL = 1'b0; PENABLE = 1'b0; inPort = 8'h00;
    cyc(2);
    chk("rst_prdata", PRDATA, 32'd0);
    chk("rst_pready", 32'(PREADY), 32'd0);
    chk("rst_pslverr", 32'(PSLVERR), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    PRESET = 1'b0;
    cyc(2);

    wr(5'h00, 32'h0, "w_moder0");
    inPort = 8'hA5;
    cyc(2);
    rd(5'h04, 32'h0000_00A5, "r_idr_a5");
    wr(5'h00, 32'hFFFF_FF0F, "w_moder0f");
    rd(5'h00, 32'h0000_000F, "r_moder_mask");
    rd(5'h04, 32'h0000_00A0, "r_idr_masked");
    wr(5'h00, 32'h0, "w_moder0b");

    inPort = 8'h00;
    cyc(4);
    wr(5'h08, 32'h01, "w_rier");
    wr(5'h14, 32'h01, "w_ierglb");
    rd(5'h10, 32'h0, "r_isr_idle");
    inPort = 8'h01;
    cyc(2);
    chk("irq_edge2", 32'(irq), 32'd0);
    cyc(1);
    chk("irq_edge3", 32'(irq), 32'd1);
    rd(5'h10, 32'h01, "r_isr_rise");
    wr(5'h10, 32'h01, "w_isr_clr");
    rd(5'h10, 32'h00, "r_isr_cleared");
    chk("irq_cleared", 32'(irq), 32'd0);

    wr(5'h0C, 32'h80, "w_fier");
    wr(5'h00, 32'h80, "w_moder80");
    inPort = 8'h81;
    cyc(4);
    inPort = 8'h01;
    cyc(4);
    rd(5'h10, 32'h00, "r_isr_disabled");
    wr(5'h00, 32'h00, "w_moder00");
    rd(5'h10, 32'h00, "r_isr_moder_tgl");
    inPort = 8'h81;
    cyc(4);
    inPort = 8'h01;
    cyc(4);
    rd(5'h13, 32'h80, "r_isr_fall");
    wr(5'h10, 32'h80, "w_isr_clr80");

    inPort = 8'h80;
    cyc(4);
    inPort = 8'h81;
    cyc(4);
    inPort = 8'h80;
    cyc(4);
    rd(5'h10, 32'h01, "r_isr_pend");
    inPort = 8'h81;
    wr(5'h10, 32'h01, "w_isr_race");
    rd(5'h10, 32'h01, "r_isr_setwins");
    chk("irq_setwins", 32'(irq), 32'd1);

    apb(1'b0, 5'h18, '0, 32'h0, 1'b1, "r_unmapped18");
    apb(1'b1, 5'h1C, 32'hFF, '0, 1'b1, "w_unmapped1c");
    wr(5'h04, 32'hFF, "w_idr");
    rd(5'h04, 32'h81, "r_idr_after_w");
    rd(5'h14, 32'h01, "r_ierglb");

    wr(5'h08, 32'hFF, "w_rier_ff");
    inPort = 8'h00;
    cyc(4);
    inPort = 8'hFF;
    cyc(4);
    rd(5'h10, 32'hFF, "r_isr_ff");
    chk("irq_pre_rst", 32'(irq), 32'd1);

    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 5'h10; PWRITE = 1'b0;
    cyc(1);
    PENABLE = 1'b1;
    #2;
    PRESET = 1'b1;
    #1;
    chk("midrst_prdata", PRDATA, 32'd0);
    chk("midrst_pready", 32'(PREADY), 32'd0);
    chk("midrst_pslverr", 32'(PSLVERR), 32'd0);
    chk("midrst_irq", 32'(irq), 32'd0);
    cyc(1);
    PSEL = 1'b0; PENABLE = 1'b0;
    PRESET = 1'b0;
    last_rd = '0;
    rd(5'h10, 32'h00, "r_isr_post_rst");
    rd(5'h08, 32'h00, "r_rier_post_rst");
    rd(5'h04, 32'hFF, "r_idr_post_rst");

    cyc(4);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
